// File: rtl/br_pkg.sv
// Shared types and helpers for the branch resolve queue.
package br_pkg;

    localparam int BR_Q_DEPTH = 8;
    localparam int BR_TAG_W   = $clog2(BR_Q_DEPTH);

    typedef logic [BR_TAG_W-1:0] br_tag_t;

    typedef struct packed {
        logic        valid;
        logic        resolved;
        logic [63:0] pc;
        logic        is_cond;
        logic        pred_taken;
        logic [63:0] pred_target;
        logic        act_taken;
        logic [63:0] act_target;
    } br_entry_t;

    // A taken branch mispredicts on a wrong target even when the direction was right.
    function automatic logic br_mispred(input logic        pred_taken,
                                        input logic [63:0] pred_target,
                                        input logic        act_taken,
                                        input logic [63:0] act_target);
        return (act_taken != pred_taken) || (act_taken && (act_target != pred_target));
    endfunction

endpackage

// File: rtl/br_resolve_q.sv
// In-order branch tracking queue: allocates at dispatch, resolves out of order,
// redirects on mispredict and retires in order onto the predictor update bus.
module br_resolve_q
    import br_pkg::*;
#(
    parameter int DEPTH = BR_Q_DEPTH,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid_i,
    input  logic [63:0]      alloc_pc_i,
    input  logic             alloc_is_cond_i,
    input  logic             alloc_pred_taken_i,
    input  logic [63:0]      alloc_pred_target_i,
    output logic             alloc_ready_o,
    output logic [TAG_W-1:0] alloc_tag_o,
    input  logic             ex_valid_i,
    input  logic [TAG_W-1:0] ex_tag_i,
    input  logic             ex_taken_i,
    input  logic [63:0]      ex_target_i,
    output logic             recover_o,
    output logic [63:0]      recover_pc_o,
    output logic [TAG_W-1:0] recover_tag_o,
    output logic             ex_is_br_o,
    output logic             ex_is_cond_o,
    output logic             ex_is_taken_o,
    output logic [63:0]      ex_pc_o,
    output logic [63:0]      ex_br_target_o,
    output logic             empty_o
);

    br_entry_t        q [DEPTH];
    logic [TAG_W-1:0] head, tail, tag_age;
    logic [TAG_W:0]   count, count_nxt;
    br_entry_t        res_e, head_e;
    logic             res_fire, mispred, retire, alloc_fire;
    logic [DEPTH-1:0] squash;

    assign res_e      = q[ex_tag_i];
    assign head_e     = q[head];
    assign res_fire   = ex_valid_i && res_e.valid && !res_e.resolved;
    assign mispred    = res_fire && br_mispred(res_e.pred_taken, res_e.pred_target,
                                               ex_taken_i, ex_target_i);
    assign retire     = head_e.valid && head_e.resolved;
    assign alloc_ready_o = (count < (TAG_W+1)'(DEPTH)) && !mispred && !recover_o;
    assign alloc_fire = alloc_valid_i && alloc_ready_o;
    assign alloc_tag_o = tail;
    assign empty_o    = (count == '0);
    assign tag_age    = ex_tag_i - head;

    // Younger-than-resolving is judged by distance from head, so wrap is handled.
    always_comb begin
        squash = '0;
        for (int i = 0; i < DEPTH; i++)
            squash[i] = mispred && ((TAG_W'(i) - head) > tag_age);
    end

    always_comb begin
        count_nxt = count + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(retire);
        if (mispred)
            count_nxt = {1'b0, tag_age} + (TAG_W+1)'(1) - (TAG_W+1)'(retire);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else begin
            count <= count_nxt;
            if (retire) begin
                q[head].valid <= 1'b0;
                head          <= head + TAG_W'(1);
            end
            if (res_fire) begin
                q[ex_tag_i].resolved   <= 1'b1;
                q[ex_tag_i].act_taken  <= ex_taken_i;
                q[ex_tag_i].act_target <= ex_target_i;
            end
            for (int i = 0; i < DEPTH; i++)
                if (squash[i]) q[i].valid <= 1'b0;
            if (mispred) begin
                tail <= ex_tag_i + TAG_W'(1);
            end else if (alloc_fire) begin
                q[tail] <= '{valid: 1'b1, resolved: 1'b0, pc: alloc_pc_i,
                             is_cond: alloc_is_cond_i, pred_taken: alloc_pred_taken_i,
                             pred_target: alloc_pred_target_i,
                             act_taken: 1'b0, act_target: 64'd0};
                tail <= tail + TAG_W'(1);
            end
        end
    end

    // Redirect and predictor-update registers; data fields hold between pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            recover_o      <= 1'b0;
            recover_pc_o   <= '0;
            recover_tag_o  <= '0;
            ex_is_br_o     <= 1'b0;
            ex_is_cond_o   <= 1'b0;
            ex_is_taken_o  <= 1'b0;
            ex_pc_o        <= '0;
            ex_br_target_o <= '0;
        end else begin
            recover_o  <= mispred;
            ex_is_br_o <= retire;
            if (mispred) begin
                recover_tag_o <= ex_tag_i;
                recover_pc_o  <= ex_taken_i ? ex_target_i : res_e.pc + 64'd4;
            end
            if (retire) begin
                ex_is_cond_o   <= head_e.is_cond;
                ex_is_taken_o  <= head_e.act_taken;
                ex_pc_o        <= head_e.pc;
                ex_br_target_o <= head_e.act_target;
            end
        end
    end

endmodule

// File: tb/tb_br_resolve_q.sv
// Randomized and directed bench for br_resolve_q against an in-order queue model.
module tb_br_resolve_q;

    localparam int D  = 8;
    localparam int TW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_valid_i, alloc_is_cond_i, alloc_pred_taken_i;
    logic [63:0]   alloc_pc_i, alloc_pred_target_i;
    logic          alloc_ready_o;
    logic [TW-1:0] alloc_tag_o;
    logic          ex_valid_i, ex_taken_i;
    logic [TW-1:0] ex_tag_i;
    logic [63:0]   ex_target_i;
    logic          recover_o;
    logic [63:0]   recover_pc_o;
    logic [TW-1:0] recover_tag_o;
    logic          ex_is_br_o, ex_is_cond_o, ex_is_taken_o;
    logic [63:0]   ex_pc_o, ex_br_target_o;
    logic          empty_o;

    br_resolve_q #(.DEPTH(D), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid_i(alloc_valid_i), .alloc_pc_i(alloc_pc_i),
        .alloc_is_cond_i(alloc_is_cond_i), .alloc_pred_taken_i(alloc_pred_taken_i),
        .alloc_pred_target_i(alloc_pred_target_i),
        .alloc_ready_o(alloc_ready_o), .alloc_tag_o(alloc_tag_o),
        .ex_valid_i(ex_valid_i), .ex_tag_i(ex_tag_i), .ex_taken_i(ex_taken_i),
        .ex_target_i(ex_target_i),
        .recover_o(recover_o), .recover_pc_o(recover_pc_o), .recover_tag_o(recover_tag_o),
        .ex_is_br_o(ex_is_br_o), .ex_is_cond_o(ex_is_cond_o), .ex_is_taken_o(ex_is_taken_o),
        .ex_pc_o(ex_pc_o), .ex_br_target_o(ex_br_target_o), .empty_o(empty_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [63:0] pc;
        bit          cond, pt, res, at;
        logic [63:0] ptg, atg;
    } ment_t;

    // Model: in-flight branches in program order, plus expected registered outputs.
    ment_t       mq[$];
    int          mtail;
    bit          rec_q, upd_q;
    logic [63:0] rec_pc;
    int          rec_tag;
    ment_t       upd_e;
    int          n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, check outputs against the model, advance the model.
    task automatic step(input bit av, input logic [63:0] apc, input bit ac, input bit apt,
                        input logic [63:0] aptg, input bit ev, input int et,
                        input bit etk, input logic [63:0] etg);
        int    idx;
        bit    mis, rdy, ret, hit;
        ment_t e;
        alloc_valid_i = av; alloc_pc_i = apc; alloc_is_cond_i = ac;
        alloc_pred_taken_i = apt; alloc_pred_target_i = aptg;
        ex_valid_i = ev; ex_tag_i = TW'(et); ex_taken_i = etk; ex_target_i = etg;
        #1;
        idx = -1;
        foreach (mq[i]) if (mq[i].tag == et) idx = i;
        hit = ev && idx >= 0 && !mq[idx].res;
        mis = 0;
        if (hit) begin
            if (etk != mq[idx].pt) mis = 1;
            else if (etk && etg != mq[idx].ptg) mis = 1;
        end
        rdy = (mq.size() < D) && !mis && !rec_q;
        ret = (mq.size() > 0) && mq[0].res;
        chk("alloc_ready", 64'(alloc_ready_o), 64'(rdy));
        chk("alloc_tag", 64'(alloc_tag_o), 64'(mtail));
        chk("empty", 64'(empty_o), 64'(mq.size() == 0));
        chk("recover", 64'(recover_o), 64'(rec_q));
        if (rec_q) begin
            chk("recover_pc", recover_pc_o, rec_pc);
            chk("recover_tag", 64'(recover_tag_o), 64'(rec_tag));
        end
        chk("upd_valid", 64'(ex_is_br_o), 64'(upd_q));
        if (upd_q) begin
            chk("upd_pc", ex_pc_o, upd_e.pc);
            chk("upd_cond", 64'(ex_is_cond_o), 64'(upd_e.cond));
            chk("upd_taken", 64'(ex_is_taken_o), 64'(upd_e.at));
            chk("upd_target", ex_br_target_o, upd_e.atg);
        end
        upd_q = ret;
        if (ret) upd_e = mq[0];
        rec_q = mis;
        if (hit) begin
            mq[idx].res = 1; mq[idx].at = etk; mq[idx].atg = etg;
        end
        if (mis) begin
            rec_pc  = etk ? etg : mq[idx].pc + 64'd4;
            rec_tag = et;
            while (mq.size() > idx + 1) void'(mq.pop_back());
            mtail = (et + 1) % D;
        end
        if (ret) void'(mq.pop_front());
        if (av && rdy) begin
            e.tag = mtail; e.pc = apc; e.cond = ac; e.pt = apt; e.ptg = aptg;
            e.res = 0; e.at = 0; e.atg = '0;
            mq.push_back(e);
            mtail = (mtail + 1) % D;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, '0, 0, 0, 0, '0);
    endtask

    task automatic alloc(input logic [63:0] pc, input bit apt, input logic [63:0] tgt);
        step(1, pc, 1, apt, tgt, 0, 0, 0, '0);
    endtask

    task automatic resolve(input int tag, input bit tk, input logic [63:0] tgt);
        step(0, '0, 0, 0, '0, 1, tag, tk, tgt);
    endtask

    // Called at a negedge; reset hits mid-cycle and must take effect immediately.
    task automatic do_reset();
        #2 rst = 1'b0;
        alloc_valid_i = 0; ex_valid_i = 0;
        #1;
        chk("rst_empty", 64'(empty_o), 64'd1);
        chk("rst_ready", 64'(alloc_ready_o), 64'd1);
        chk("rst_tag", 64'(alloc_tag_o), 64'd0);
        chk("rst_recover", 64'(recover_o), 64'd0);
        chk("rst_upd", 64'(ex_is_br_o), 64'd0);
        chk("rst_recpc", recover_pc_o, 64'd0);
        chk("rst_updpc", ex_pc_o, 64'd0);
        mq.delete(); mtail = 0; rec_q = 0; upd_q = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int          ut[$];
        int          et;
        bit          etk, apt;
        logic [63:0] apc, ptg, etg;
        rst = 1'b1;
        alloc_valid_i = 0; alloc_pc_i = '0; alloc_is_cond_i = 0; alloc_pred_taken_i = 0;
        alloc_pred_target_i = '0; ex_valid_i = 0; ex_tag_i = '0; ex_taken_i = 0;
        ex_target_i = '0;
        @(negedge clk);
        do_reset();

        // Correct not-taken prediction: no redirect, update two cycles after resolve.
        alloc(64'h100, 0, 64'h0);
        resolve(0, 0, 64'h0);
        chk("t1_no_recover", 64'(recover_o), 64'd0);
        idle(1);
        chk("t1_upd", 64'(ex_is_br_o), 64'd1);
        chk("t1_pc", ex_pc_o, 64'h100);
        chk("t1_taken", 64'(ex_is_taken_o), 64'd0);
        idle(2);

        // Taken with wrong target.
        do_reset();
        alloc(64'h200, 1, 64'h400);
        resolve(0, 1, 64'h480);
        chk("t2_recover", 64'(recover_o), 64'd1);
        chk("t2_pc", recover_pc_o, 64'h480);
        chk("t2_tag", 64'(recover_tag_o), 64'd0);
        idle(3);

        // Squash of younger entries behind a direction mispredict.
        do_reset();
        alloc(64'h10, 1, 64'h800); alloc(64'h40, 1, 64'h800);
        alloc(64'h50, 1, 64'h800); alloc(64'h60, 1, 64'h800);
        resolve(1, 0, 64'h0);
        chk("t3_pc", recover_pc_o, 64'h44);
        chk("t3_tail", 64'(alloc_tag_o), 64'd2);
        alloc(64'h70, 0, 64'h0);
        alloc(64'h70, 0, 64'h0);
        resolve(0, 1, 64'h800); resolve(1, 0, 64'h0); resolve(2, 0, 64'h0);
        idle(5);

        // Fill, hold a ninth request, then drain one and wrap the tag.
        do_reset();
        for (int i = 0; i < D; i++) alloc(64'h1000 + 64'(i * 4), 0, 64'h0);
        chk("t4_full", 64'(alloc_ready_o), 64'd0);
        alloc(64'h2000, 0, 64'h0);
        step(1, 64'h2000, 1, 0, '0, 1, 0, 0, '0);
        alloc(64'h2000, 0, 64'h0);
        chk("t4_ready", 64'(alloc_ready_o), 64'd1);
        chk("t4_wrap_tag", 64'(alloc_tag_o), 64'd0);
        alloc(64'h2000, 0, 64'h0);
        for (int i = 1; i < D; i++) resolve(i, 0, 64'h0);
        resolve(0, 0, 64'h0);
        idle(4);

        // Out-of-order resolution retires in order.
        do_reset();
        alloc(64'h300, 0, 64'h0); alloc(64'h304, 0, 64'h0); alloc(64'h308, 0, 64'h0);
        resolve(2, 0, 64'h0); resolve(0, 0, 64'h0); resolve(1, 0, 64'h0);
        idle(4);

        // Reset mid-stream with five entries and a redirect pending.
        do_reset();
        for (int i = 0; i < 5; i++) alloc(64'h500 + 64'(i * 4), 0, 64'h0);
        resolve(4, 1, 64'h900);
        chk("t6_pending", 64'(recover_o), 64'd1);
        do_reset();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            apc = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC
                                              : {$urandom, $urandom} & ~64'h3;
            apt = 1'($urandom);
            ptg = 64'(($urandom_range(0, 1) + 1) * 64'h1000);
            ut.delete();
            foreach (mq[i]) if (!mq[i].res) ut.push_back(i);
            etk = 1'($urandom);
            etg = 64'(($urandom_range(0, 2) + 1) * 64'h1000);
            if (ut.size() > 0 && $urandom_range(0, 3) != 0) begin
                int k;
                k  = ut[$urandom_range(0, ut.size() - 1)];
                et = mq[k].tag;
                if ($urandom_range(0, 3) != 0) begin
                    etk = mq[k].pt;
                    etg = mq[k].ptg;
                end
            end else begin
                et = $urandom_range(0, D - 1);
            end
            step($urandom_range(0, 9) < 7, apc, 1'($urandom), apt, ptg,
                 $urandom_range(0, 1) == 1, et, etk, etg);
        end
        idle(D + 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
